// File: rtl/axis_tgl_credit_rx_pkg.sv
// Shared constants for the toggle-event credit scheme. The transmit side
// imports the same package so both ends agree on the credit limit.
package axis_tgl_pkg;

  localparam int AXIS_TGL_CNT_W_DEF = 4;
  localparam int AXIS_TGL_SYNC_DEF  = 2;

  // Largest count a CNT_WIDTH-bit credit counter can hold.
  function automatic int axis_tgl_cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int AXIS_TGL_CNT_MAX_DEF = axis_tgl_cnt_max(AXIS_TGL_CNT_W_DEF);

endpackage

// File: rtl/axis_tgl_credit_rx_if.sv
// Token stream presented to the local consumer: valid/ready plus the
// current pending-token count.
interface axis_tgl_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 m_axis_valid;
  logic                 m_axis_ready;
  logic [CNT_WIDTH-1:0] pending;

  modport master (
    output m_axis_valid,
    output pending,
    input  m_axis_ready
  );

  modport slave (
    input  m_axis_valid,
    input  pending,
    output m_axis_ready
  );
endinterface

// File: rtl/axis_tgl_credit_rx_edge_sync.sv
// Synchronizes an asynchronous toggle wire and turns every transition into
// a single-cycle pulse. Shared with the transmitter, which watches tgl_ack.
module tgl_edge_sync
  import axis_tgl_pkg::*;
#(
  parameter int SYNC_STAGES = AXIS_TGL_SYNC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl_in,
  output logic inc
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Next state: shift the toggle in and remember the last synchronized level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tgl_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer chain and edge-detect history, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Any level change at the synchronizer output is one token.
  assign inc = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/axis_tgl_credit_rx.sv
// Receive side of the toggle-event flow control: counts tokens arriving as
// transitions on tgl_in, hands them out over valid/ready, and returns one
// tgl_ack transition per consumed token.
module axis_tgl_credit_rx
  import axis_tgl_pkg::*;
#(
  parameter int CNT_WIDTH   = AXIS_TGL_CNT_W_DEF,
  parameter int SYNC_STAGES = AXIS_TGL_SYNC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tgl_in,
  output logic        tgl_ack,
  output logic        ovf,
  input  logic        ovf_clr,
  axis_tgl_if.master  m_axis
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(axis_tgl_cnt_max(CNT_WIDTH));

  logic                 inc;
  logic                 dec;
  logic                 valid;
  logic                 ovf_evt;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic                 ovf_q, ovf_d;

  tgl_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .tgl_in (tgl_in),
    .inc    (inc)
  );

  // valid depends on the count register only, never on ready, so a
  // consumer may wait for valid before raising ready.
  assign valid = (cnt_q != '0);
  assign dec   = valid & m_axis.m_axis_ready;

  // Credit counter, ack toggle and sticky overflow next-state.
  always_comb begin
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    ovf_evt = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) begin
        ovf_evt = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!inc && dec) begin
      cnt_d = cnt_q - 1'b1;
    end
    // A simultaneous token and transfer leaves the count alone and cannot
    // overflow, even when full.
    if (dec) begin
      ack_d = ~ack_q;
    end
    // A fresh overflow beats a clear in the same cycle so no loss goes unseen.
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers; reset discards all pending tokens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      ovf_q <= ovf_d;
    end
  end

  assign m_axis.m_axis_valid = valid;
  assign m_axis.pending      = cnt_q;
  assign tgl_ack             = ack_q;
  assign ovf                 = ovf_q;

endmodule
